fpu_pcx_assembler: RTL

FPU_PCX_ASSEMBLER -- requirements
Module: fpu_pcx_assembler

---
 rtl/fpu_pcx_pkg.sv | 28 ++
 rtl/sat_counter.sv | 30 +++
 rtl/fpu_pcx_assembler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fpu_pcx_pkg.sv
// Shared constants and types for the PCX-to-FPU request assembler.
package fpu_pcx_pkg;

    localparam logic [4:0] PCX_FP1  = 5'b01010;
    localparam logic [4:0] PCX_FP2  = 5'b01011;
    localparam logic [7:0] OP_FADDD = 8'h42;
    localparam logic [7:0] OP_FMULD = 8'h4A;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAVE_OP1 = 2'd1,
        ST_FULL     = 2'd2
    } pcx_state_e;

    typedef struct packed {
        logic [2:0] cpu_id;
        logic [1:0] thread_id;
        logic [7:0] opcode;
        logic [1:0] cc;
        logic [1:0] rmode;
    } fpu_meta_t;

    // Two FP2 halves belong together only if they come from the same thread and agree on the op.
    function automatic logic same_source(input fpu_meta_t a, input fpu_meta_t b);
        return (a.cpu_id == b.cpu_id) && (a.thread_id == b.thread_id) && (a.opcode == b.opcode);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fpu_pcx_assembler.sv
// Collects one (FP1) or two (FP2) PCX packets into a single FPU request and
// holds it until the FPU takes it; counts protocol errors and completed requests.
module fpu_pcx_assembler
    import fpu_pcx_pkg::*;
#(
    parameter int ERR_CNT_W = 8,
    parameter int OPS_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 pcx_valid,
    output logic                 pcx_ready,
    input  logic [4:0]           pcx_req_type,
    input  logic [2:0]           pcx_cpu_id,
    input  logic [1:0]           pcx_thread_id,
    input  logic [63:0]          pcx_data,
    input  logic [7:0]           pcx_opcode,
    input  logic [1:0]           pcx_cc,
    input  logic [1:0]           pcx_rmode,
    output logic                 fpu_req_valid,
    input  logic                 fpu_req_ready,
    output logic [63:0]          fpu_rs1,
    output logic [63:0]          fpu_rs2,
    output logic [7:0]           fpu_opcode,
    output logic [2:0]           fpu_cpu_id,
    output logic [1:0]           fpu_thread_id,
    output logic [1:0]           fpu_cc,
    output logic [1:0]           fpu_rmode,
    output logic                 err_type,
    output logic                 err_mismatch,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [OPS_CNT_W-1:0] ops_count
);

    pcx_state_e           state_q, state_d;
    logic [63:0]          rs1_q, rs1_d, rs2_q, rs2_d;
    fpu_meta_t            meta_q, meta_d, pkt_meta;
    logic                 req_valid_q, req_valid_d;
    logic                 err_type_q, err_type_d;
    logic                 err_mm_q, err_mm_d;
    logic [OPS_CNT_W-1:0] ops_q, ops_d;
    logic                 accept, is_fp1, is_fp2;

    assign accept   = pcx_valid & pcx_ready;
    assign is_fp1   = (pcx_req_type == PCX_FP1);
    assign is_fp2   = (pcx_req_type == PCX_FP2);
    assign pkt_meta = '{cpu_id: pcx_cpu_id, thread_id: pcx_thread_id, opcode: pcx_opcode,
                        cc: pcx_cc, rmode: pcx_rmode};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        meta_d     = meta_q;
        err_type_d = 1'b0;
        err_mm_d   = 1'b0;
        ops_d      = ops_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_fp2) begin
                        rs1_d   = pcx_data;
                        rs2_d   = '0;
                        meta_d  = pkt_meta;
                        state_d = ST_HAVE_OP1;
                    end else if (is_fp1) begin
                        rs1_d   = '0;
                        rs2_d   = pcx_data;
                        meta_d  = pkt_meta;
                        state_d = ST_FULL;
                    end else begin
                        err_type_d = 1'b1;
                    end
                end
            end
            ST_HAVE_OP1: begin
                if (accept) begin
                    if (is_fp2 && same_source(meta_q, pkt_meta)) begin
                        rs2_d        = pcx_data;
                        meta_d.cc    = pcx_cc;
                        meta_d.rmode = pcx_rmode;
                        state_d      = ST_FULL;
                    end else if (is_fp2) begin
                        // Orphaned first half: restart the pair from this packet.
                        err_mm_d = 1'b1;
                        rs1_d    = pcx_data;
                        rs2_d    = '0;
                        meta_d   = pkt_meta;
                    end else if (is_fp1) begin
                        err_mm_d = 1'b1;
                        rs1_d    = '0;
                        rs2_d    = pcx_data;
                        meta_d   = pkt_meta;
                        state_d  = ST_FULL;
                    end else begin
                        err_type_d = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (fpu_req_ready) begin
                    state_d = ST_IDLE;
                    ops_d   = ops_q + OPS_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_valid_d = (state_d == ST_FULL);
    end

    always_comb begin
        pcx_ready = (state_q == ST_IDLE) || (state_q == ST_HAVE_OP1);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rs1_q       <= '0;
            rs2_q       <= '0;
            meta_q      <= '0;
            req_valid_q <= 1'b0;
            err_type_q  <= 1'b0;
            err_mm_q    <= 1'b0;
            ops_q       <= '0;
        end else begin
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            meta_q      <= meta_d;
            req_valid_q <= req_valid_d;
            err_type_q  <= err_type_d;
            err_mm_q    <= err_mm_d;
            ops_q       <= ops_d;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_l (rst_l),
        .inc   (err_type_d | err_mm_d),
        .count (err_count)
    );

    assign fpu_req_valid = req_valid_q;
    assign fpu_rs1       = rs1_q;
    assign fpu_rs2       = rs2_q;
    assign fpu_opcode    = meta_q.opcode;
    assign fpu_cpu_id    = meta_q.cpu_id;
    assign fpu_thread_id = meta_q.thread_id;
    assign fpu_cc        = meta_q.cc;
    assign fpu_rmode     = meta_q.rmode;
    assign err_type      = err_type_q;
    assign err_mismatch  = err_mm_q;
    assign ops_count     = ops_q;

endmodule
